// File: rtl/latch_wr_sched_if.sv
// Requester, latch-bank and status signals of the latch write scheduler; READBACK_CHECK_EN adds readback/error.
// Latency and backpressure: none (pure wiring); requesters hold req until their done pulse.
interface latch_wr_sched_if #(
   parameter int NREQ = 4,
   parameter int NENT = 8,
   parameter int DW   = 8,
   parameter int AW   = 3
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [NENT-1:0]    lat_en;
   logic [DW-1:0]      lat_d;
   logic               busy;
`ifdef READBACK_CHECK_EN
   logic [NENT*DW-1:0] lat_q;
   logic               err;
   logic [AW-1:0]      err_addr;
`endif

   modport master (
      output req, addr, wdata,
      input  gnt, done, lat_en, lat_d, busy
`ifdef READBACK_CHECK_EN
      , output lat_q
      , input  err, err_addr
`endif
   );

   modport slave (
      input  req, addr, wdata,
      output gnt, done, lat_en, lat_d, busy
`ifdef READBACK_CHECK_EN
      , input  lat_q
      , output err, err_addr
`endif
   );
endinterface

// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a latch register file: setup/open/hold per write, done SETUP+OPEN+HOLD cycles after grant.
// Requesters hold req until done; losers simply wait. READBACK_CHECK_EN adds a latch readback compare.
module latch_wr_sched #(
   parameter int NREQ      = 4,
   parameter int NENT      = 8,
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int SETUP_CYC = 1,
   parameter int OPEN_CYC  = 2,
   parameter int HOLD_CYC  = 1
) (
   input logic             clk,
   input logic             rst_n,
   latch_wr_sched_if.slave bus
);
   localparam int CMAX0 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
   localparam int CMAX  = (CMAX0 > HOLD_CYC) ? CMAX0 : HOLD_CYC;
   localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   rr_ptr;
   logic [AW-1:0]   addr_q;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic [NENT-1:0] lat_en;
   logic [DW-1:0]   lat_d;
   logic            busy;

   logic [PW-1:0]   win;
   logic            win_vld;
   logic [NENT-1:0] en_dec;
   logic            last_hold;

   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      win_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (bus.req[idx]) begin
            win     = PW'(idx);
            win_vld = 1'b1;
         end
      end
   end

   // Out-of-range addresses decode to all-zero, so no entry opens.
   always_comb begin
      en_dec = '0;
      for (int e = 0; e < NENT; e++) en_dec[e] = (addr_q == AW'(e));
   end

   assign last_hold = ((state == OPEN) && (cnt == '0) && (HOLD_CYC == 1)) ||
                      ((state == HOLD) && (cnt == CW'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rr_ptr <= '0;
         addr_q <= '0;
         gnt    <= '0;
         done   <= '0;
         lat_en <= '0;
         lat_d  <= '0;
         busy   <= 1'b0;
      end else begin
         done <= last_hold ? gnt : '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state  <= SETUP;
                  cnt    <= CW'(SETUP_CYC - 1);
                  gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                  lat_d  <= bus.wdata[int'(win)*DW +: DW];
                  addr_q <= bus.addr[int'(win)*AW +: AW];
                  rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                  busy   <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state  <= OPEN;
                  cnt    <= CW'(OPEN_CYC - 1);
                  lat_en <= en_dec;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            OPEN: begin
               if (cnt == '0) begin
                  state  <= HOLD;
                  cnt    <= CW'(HOLD_CYC - 1);
                  lat_en <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt    = gnt;
   assign bus.done   = done;
   assign bus.lat_en = lat_en;
   assign bus.lat_d  = lat_d;
   assign bus.busy   = busy;

`ifdef READBACK_CHECK_EN
   logic [DW-1:0] q_sel;
   logic          in_range;
   logic          err;
   logic [AW-1:0] err_addr;

   always_comb begin
      q_sel    = '0;
      in_range = 1'b0;
      for (int e = 0; e < NENT; e++) begin
         if (addr_q == AW'(e)) begin
            q_sel    = bus.lat_q[e*DW +: DW];
            in_range = 1'b1;
         end
      end
   end

   // Sampled on the same edge that raises done, so err lines up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         err_addr <= '0;
      end else begin
         err <= 1'b0;
         if (last_hold && in_range && (q_sel != lat_d)) begin
            err      <= 1'b1;
            err_addr <= addr_q;
         end
      end
   end

   assign bus.err      = err;
   assign bus.err_addr = err_addr;
`endif
endmodule

// File: tb/tb_latch_wr_sched.sv
// Directed bench for latch_wr_sched: single write, round-robin, data stability, async reset, edge cases, readback.
// AW is widened to 4 so an out-of-range address (9) can be presented with NENT=8.
module tb_latch_wr_sched;
   localparam int NREQ = 4;
   localparam int NENT = 8;
   localparam int DW   = 8;
   localparam int AW   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   latch_wr_sched_if #(.NREQ(NREQ), .NENT(NENT), .DW(DW), .AW(AW)) bus ();

   latch_wr_sched #(
      .NREQ(NREQ), .NENT(NENT), .DW(DW), .AW(AW),
      .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef READBACK_CHECK_EN
   // Latch bank model with bit 0 of every entry stuck at 0.
   logic [NENT*DW-1:0] lq = '0;
   always @(bus.lat_en or bus.lat_d) begin
      for (int e = 0; e < NENT; e++)
         if (bus.lat_en[e]) lq[e*DW +: DW] = {bus.lat_d[DW-1:1], 1'b0};
   end
   assign bus.lat_q = lq;
`endif

   int vec  = 0;
   int errs = 0;
   logic [NENT-1:0] prev_en = '0;
   logic [DW-1:0]   prev_d  = '0;
   int ngr, low_run;
   logic [NREQ-1:0] pg;
   logic [NENT-1:0] pe;
   logic [DW-1:0]   tog;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, and check the standing invariants.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("lat_en_onehot0", 32'($onehot0(bus.lat_en)), 32'd1);
      if (bus.lat_en != '0 && prev_en != '0) chk("lat_d_stable_open", 32'(bus.lat_d), 32'(prev_d));
      prev_en = bus.lat_en;
      prev_d  = bus.lat_d;
   endtask

   task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.addr[i*AW +: AW]  = a;
      bus.wdata[i*DW +: DW] = d;
   endtask

   initial begin
      bus.req   = '0;
      bus.addr  = '0;
      bus.wdata = '0;

      // Reset values
      #3;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_lat_en", 32'(bus.lat_en), 32'd0);
      chk("rst_lat_d", 32'(bus.lat_d), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef READBACK_CHECK_EN
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_err_addr", 32'(bus.err_addr), 32'd0);
`endif
      #9 rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // 1. Single write: req[2], addr 5, data A5
      set_port(2, 4'd5, 8'hA5);
      bus.req = 4'b0100;
      tick();
      chk("t1_gnt_e1", 32'(bus.gnt), 32'h4);
      chk("t1_lat_d_e1", 32'(bus.lat_d), 32'hA5);
      chk("t1_busy_e1", 32'(bus.busy), 32'd1);
      chk("t1_lat_en_e1", 32'(bus.lat_en), 32'd0);
      tick();
      chk("t1_lat_en_e2", 32'(bus.lat_en), 32'h20);
      chk("t1_done_e2", 32'(bus.done), 32'd0);
      tick();
      chk("t1_lat_en_e3", 32'(bus.lat_en), 32'h20);
      tick();
      chk("t1_lat_en_e4", 32'(bus.lat_en), 32'd0);
      chk("t1_done_e4", 32'(bus.done), 32'h4);
      chk("t1_gnt_e4", 32'(bus.gnt), 32'h4);
      chk("t1_lat_d_e4", 32'(bus.lat_d), 32'hA5);
      bus.req = '0;
      tick();
      chk("t1_done_e5", 32'(bus.done), 32'd0);
      chk("t1_gnt_e5", 32'(bus.gnt), 32'd0);
      chk("t1_busy_e5", 32'(bus.busy), 32'd0);

      // 2. Round-robin from a fresh reset (pointer was left at 3)
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_port(i, AW'(i), 8'h10 + 8'(i));
      bus.req = 4'b1111;
      ngr = 0; low_run = 0; pg = '0; pe = '0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (bus.gnt != '0 && pg == '0) begin
            chk("rr_gnt", 32'(bus.gnt), 32'd1 << (ngr % 4));
            chk("rr_lat_d", 32'(bus.lat_d), 32'h10 + 32'(ngr % 4));
            ngr++;
         end
         if (bus.lat_en != '0 && pe == '0 && ngr > 1) chk("rr_gap_ge2", 32'(low_run >= 2), 32'd1);
         low_run = (bus.lat_en == '0) ? low_run + 1 : 0;
         pg = bus.gnt;
         pe = bus.lat_en;
      end
      chk("rr_grant_count", 32'(ngr), 32'd5);
      bus.req = '0;
      tick();
      chk("rr_idle", 32'(bus.busy), 32'd0);

      // 3. Data stability while the granted port's wdata toggles
      tog = 8'h3C;
      set_port(1, 4'd6, tog);
      bus.req = 4'b0010;
      tick();
      chk("t3_gnt", 32'(bus.gnt), 32'h2);
      chk("t3_lat_d_e1", 32'(bus.lat_d), 32'h3C);
      for (int i = 0; i < 3; i++) begin
         tog = ~tog;
         set_port(1, 4'd6, tog);
         tick();
         chk("t3_lat_d_hold", 32'(bus.lat_d), 32'h3C);
      end
      chk("t3_done", 32'(bus.done), 32'h2);
      bus.req = '0;
      tick();

      // 4. Async reset mid-OPEN, then req[3] alone
      set_port(2, 4'd5, 8'h55);
      bus.req = 4'b0100;
      tick();
      tick();
      chk("t4_lat_en_open", 32'(bus.lat_en), 32'h20);
      #3 rst_n = 1'b0;
      #1;
      chk("t4_lat_en_async", 32'(bus.lat_en), 32'd0);
      chk("t4_gnt_async", 32'(bus.gnt), 32'd0);
      chk("t4_busy_async", 32'(bus.busy), 32'd0);
      #2 rst_n = 1'b1;
      set_port(3, 4'd2, 8'h77);
      bus.req = 4'b1000;
      tick();
      chk("t4_gnt_after", 32'(bus.gnt), 32'h8);
      chk("t4_lat_d_after", 32'(bus.lat_d), 32'h77);
      tick();
      chk("t4_lat_en_after", 32'(bus.lat_en), 32'h04);
      tick();
      tick();
      chk("t4_done_after", 32'(bus.done), 32'h8);
      bus.req = '0;
      tick();

      // 5a. Out-of-range address: no latch opens, done still pulses
      set_port(0, 4'd9, 8'h99);
      bus.req = 4'b0001;
      tick();
      chk("t5a_gnt", 32'(bus.gnt), 32'h1);
      tick();
      chk("t5a_lat_en_e2", 32'(bus.lat_en), 32'd0);
      tick();
      chk("t5a_lat_en_e3", 32'(bus.lat_en), 32'd0);
      tick();
      chk("t5a_done", 32'(bus.done), 32'h1);
`ifdef READBACK_CHECK_EN
      chk("t5a_no_err", 32'(bus.err), 32'd0);
`endif
      bus.req = '0;
      tick();

      // 5b. req dropped during SETUP: the write still completes
      set_port(1, 4'd1, 8'h5A);
      bus.req = 4'b0010;
      tick();
      chk("t5b_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      tick();
      chk("t5b_lat_en", 32'(bus.lat_en), 32'h02);
      tick();
      tick();
      chk("t5b_done", 32'(bus.done), 32'h2);
      tick();
      chk("t5b_idle", 32'(bus.busy), 32'd0);

`ifdef READBACK_CHECK_EN
      // 6. Readback: 01 to entry 3 reads back 00; 02 to entry 4 reads back 02
      set_port(0, 4'd3, 8'h01);
      bus.req = 4'b0001;
      tick(); tick(); tick(); tick();
      chk("t6_done1", 32'(bus.done), 32'h1);
      chk("t6_err1", 32'(bus.err), 32'd1);
      chk("t6_err_addr1", 32'(bus.err_addr), 32'd3);
      bus.req = '0;
      tick();
      chk("t6_err_pulse", 32'(bus.err), 32'd0);
      chk("t6_err_addr_hold", 32'(bus.err_addr), 32'd3);
      set_port(0, 4'd4, 8'h02);
      bus.req = 4'b0001;
      tick(); tick(); tick(); tick();
      chk("t6_done2", 32'(bus.done), 32'h1);
      chk("t6_err2", 32'(bus.err), 32'd0);
      chk("t6_err_addr2", 32'(bus.err_addr), 32'd3);
      bus.req = '0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
